// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: a multi-cycle, wait-stated RAM with
// byte/half/word loads and stores, one-cycle ack pulse and error reporting.
//   clk, reset               : clock, synchronous active-high reset
//   req_read, req_write      : load/store request, held until ack
//   addr, wdata, acc_mode    : byte address, store data, access width/sign
//   rdata, ack, err          : completion data/pulse/error (valid with ack)
//   stall                    : hold for upstream pipeline registers and PC
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  acc_mode,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        stall
);
    localparam int         AW       = $clog2(DEPTH);
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [2:0]  l_mode;
    logic        l_rd;
    logic        l_wr;

    logic [31:0] mem [DEPTH];

    // Transaction being completed: live inputs when finishing straight out of
    // IDLE (zero wait states), otherwise the copy latched at request time.
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [2:0]  t_mode;
    logic        t_rd;
    logic        t_wr;

    assign t_addr  = (state == IDLE) ? addr      : l_addr;
    assign t_wdata = (state == IDLE) ? wdata     : l_wdata;
    assign t_mode  = (state == IDLE) ? acc_mode  : l_mode;
    assign t_rd    = (state == IDLE) ? req_read  : l_rd;
    assign t_wr    = (state == IDLE) ? req_write : l_wr;

    // High on the edge that enters ACK: store commit and load sample point.
    logic finish;
    assign finish = (NO_WAIT && state == IDLE && (req_read | req_write))
                  || (state == WAIT && cnt == 4'd0);

    assign stall = (req_read | req_write) & ~ack;

    logic mode_ok;
    logic align_ok;
    logic range_ok;
    logic t_err;

    always_comb begin
        mode_ok  = 1'b0;
        align_ok = 1'b0;
        case (t_mode)
            3'b000: begin
                mode_ok  = 1'b1;
                align_ok = (t_addr[1:0] == 2'b00);
            end
            3'b001, 3'b101: begin
                mode_ok  = 1'b1;
                align_ok = ~t_addr[0];
            end
            3'b010, 3'b110: begin
                mode_ok  = 1'b1;
                align_ok = 1'b1;
            end
            default: ;
        endcase
    end

    assign range_ok = ({2'b00, t_addr[31:2]} < 32'(DEPTH));
    assign t_err    = ~mode_ok | ~align_ok | ~range_ok | (t_rd & t_wr);

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   ld;
    logic [3:0]    be;
    logic [31:0]   wrep;

    assign idx     = t_addr[AW+1:2];
    assign word    = mem[idx];
    assign shifted = word >> {t_addr[1:0], 3'b000};

    // Narrow store data is replicated across lanes; byte enables pick lanes.
    always_comb begin
        be   = 4'h0;
        wrep = t_wdata;
        case (t_mode[1:0])
            2'b00: be = 4'hF;
            2'b01: begin
                be   = t_addr[1] ? 4'hC : 4'h3;
                wrep = {2{t_wdata[15:0]}};
            end
            default: begin
                be   = 4'b0001 << t_addr[1:0];
                wrep = {4{t_wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        ld = 32'd0;
        case (t_mode)
            3'b000:  ld = word;
            3'b001:  ld = {16'd0, shifted[15:0]};
            3'b101:  ld = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ld = {24'd0, shifted[7:0]};
            3'b110:  ld = {{24{shifted[7]}}, shifted[7:0]};
            default: ld = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_read | req_write) begin
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        l_mode  <= acc_mode;
                        l_rd    <= req_read;
                        l_wr    <= req_write;
                        cnt     <= CNT_INIT;
                        state   <= NO_WAIT ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= ACK;
                    else             cnt   <= cnt - 4'd1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (finish) begin
                ack   <= 1'b1;
                err   <= t_err;
                rdata <= (t_rd & ~t_err) ? ld : 32'd0;
            end
        end
    end

    // Memory is never cleared; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && finish && t_wr && !t_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a byte-level model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        rr    [3];
    logic        ww    [3];
    logic [31:0] aa    [3];
    logic [31:0] wd    [3];
    logic [2:0]  mm    [3];
    logic [31:0] rd_o  [3];
    logic        ack_o [3];
    logic        err_o [3];
    logic        stl_o [3];

    // u0: WAIT_CYCLES=1, u1: WAIT_CYCLES=0, u2: WAIT_CYCLES=3
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst[0]), .req_read(rr[0]), .req_write(ww[0]),
        .addr(aa[0]), .wdata(wd[0]), .acc_mode(mm[0]),
        .rdata(rd_o[0]), .ack(ack_o[0]), .err(err_o[0]), .stall(stl_o[0]));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst[1]), .req_read(rr[1]), .req_write(ww[1]),
        .addr(aa[1]), .wdata(wd[1]), .acc_mode(mm[1]),
        .rdata(rd_o[1]), .ack(ack_o[1]), .err(err_o[1]), .stall(stl_o[1]));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(rst[2]), .req_read(rr[2]), .req_write(ww[2]),
        .addr(aa[2]), .wdata(wd[2]), .acc_mode(mm[2]),
        .rdata(rd_o[2]), .ack(ack_o[2]), .err(err_o[2]), .stall(stl_o[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction from an idle responder; returns data, error, latency
    // and whether stall ever deviated from "high until ack".
    task automatic txn(input int u, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] m, output logic [31:0] ro,
                       output logic eo, output int lat, output bit sbad);
        @(negedge clk);
        rr[u] = r; ww[u] = w; aa[u] = a; wd[u] = d; mm[u] = m;
        lat  = 0;
        sbad = 0;
        #1;
        if (stl_o[u] !== 1'b1) sbad = 1;
        do begin
            @(negedge clk);
            lat++;
            if (!ack_o[u] && stl_o[u] !== 1'b1) sbad = 1;
        end while (!ack_o[u] && lat < 40);
        if (!ack_o[u]) begin
            errors++;
            $display("FAIL ack_timeout: unit %0d no ack after %0d cycles",
                     u, lat);
        end
        if (stl_o[u] !== 1'b0) sbad = 1;
        ro = rd_o[u];
        eo = err_o[u];
        rr[u] = 0; ww[u] = 0;
    endtask

    // Byte-addressed model of the randomized unit's memory.
    logic [7:0] mb [4096];

    function automatic void model(input bit r, input bit w,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] m,
                                  output logic [31:0] er, output bit ee);
        int sz = 1;
        bit sgn = 0;
        bit legal = 1;
        logic [63:0] v = 0;
        case (m)
            3'd0: sz = 4;
            3'd1: sz = 2;
            3'd2: sz = 1;
            3'd5: begin sz = 2; sgn = 1; end
            3'd6: begin sz = 1; sgn = 1; end
            default: legal = 0;
        endcase
        ee = !legal || (r && w) || (a % sz != 0) || ((a / 4) >= 1024);
        er = 0;
        if (ee) return;
        if (w)
            for (int i = 0; i < sz; i++) mb[a + i] = d[8*i +: 8];
        if (r) begin
            for (int i = 0; i < sz; i++) v = v + (64'(mb[a + i]) << (8 * i));
            if (sgn && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
            er = v[31:0];
        end
    endfunction

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  m;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] ro;
        logic        eo;
        int          lat;
        bit          sbad;
        bit          seen;

        for (int u = 0; u < 3; u++) begin
            rst[u] = 1; rr[u] = 0; ww[u] = 0;
            aa[u] = 0; wd[u] = 0; mm[u] = 0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_ack%0d", u), 32'(ack_o[u]), 0);
            chk($sformatf("rst_err%0d", u), 32'(err_o[u]), 0);
            chk($sformatf("rst_rdata%0d", u), rd_o[u], 0);
            chk($sformatf("rst_stall%0d", u), 32'(stl_o[u]), 0);
            rst[u] = 0;
        end

        vt = '{
            '{0, 1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 0},
            '{1, 0, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 0},
            '{0, 1, 32'h20, 32'h0, 3'b000, 32'h0, 0},
            '{0, 1, 32'h21, 32'hFFFFFF80, 3'b010, 32'h0, 0},
            '{0, 1, 32'h22, 32'h1234567F, 3'b010, 32'h0, 0},
            '{1, 0, 32'h20, 32'h0, 3'b000, 32'h007F8000, 0},
            '{1, 0, 32'h21, 32'h0, 3'b110, 32'hFFFFFF80, 0},
            '{1, 0, 32'h21, 32'h0, 3'b010, 32'h00000080, 0},
            '{0, 1, 32'h20, 32'h80011234, 3'b000, 32'h0, 0},
            '{1, 0, 32'h22, 32'h0, 3'b101, 32'hFFFF8001, 0},
            '{0, 1, 32'h23, 32'hFFFF, 3'b101, 32'h0, 1},
            '{1, 0, 32'h23, 32'h0, 3'b101, 32'h0, 1},
            '{1, 0, 32'h20, 32'h0, 3'b000, 32'h80011234, 0},
            '{1, 0, 32'h1000, 32'h0, 3'b000, 32'h0, 1},
            '{1, 1, 32'h20, 32'h11111111, 3'b000, 32'h0, 1},
            '{1, 0, 32'h20, 32'h0, 3'b000, 32'h80011234, 0},
            '{1, 0, 32'h20, 32'h0, 3'b011, 32'h0, 1},
            '{1, 0, 32'h22, 32'h0, 3'b000, 32'h0, 1},
            '{0, 1, 32'h22, 32'hABCD5678, 3'b001, 32'h0, 0},
            '{1, 0, 32'h20, 32'h0, 3'b000, 32'h56781234, 0},
            '{1, 0, 32'h22, 32'h0, 3'b001, 32'h00005678, 0}
        };
        foreach (vt[i]) begin
            txn(0, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].m,
                ro, eo, lat, sbad);
            chk($sformatf("vec%0d_rdata", i), ro, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(eo), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_lat", i), lat, 2);
            chk($sformatf("vec%0d_stall", i), 32'(sbad), 0);
        end

        // Reset during WAIT aborts the store.
        txn(0, 0, 1, 32'h40, 32'h12345678, 3'b000, ro, eo, lat, sbad);
        @(negedge clk);
        ww[0] = 1; aa[0] = 32'h40; wd[0] = 32'hCAFEF00D; mm[0] = 0;
        @(negedge clk);
        chk("abort_wait_ack", 32'(ack_o[0]), 0);
        rst[0] = 1; ww[0] = 0;
        @(negedge clk);
        chk("abort_ack", 32'(ack_o[0]), 0);
        chk("abort_err", 32'(err_o[0]), 0);
        chk("abort_rdata", rd_o[0], 0);
        rst[0] = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_o[0]) seen = 1;
        end
        chk("abort_no_ack", 32'(seen), 0);
        txn(0, 1, 0, 32'h40, 32'h0, 3'b000, ro, eo, lat, sbad);
        chk("abort_mem_kept", ro, 32'h12345678);

        // Reset wins over a request sampled at the same edge.
        @(negedge clk);
        rst[0] = 1; rr[0] = 1; aa[0] = 32'h40; mm[0] = 0;
        @(negedge clk);
        rst[0] = 0; rr[0] = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_o[0]) seen = 1;
        end
        chk("rst_prio_no_ack", 32'(seen), 0);

        // Zero wait states, read held for three transactions.
        txn(1, 0, 1, 32'h44, 32'h5A5A5A5A, 3'b000, ro, eo, lat, sbad);
        chk("w0_store_lat", lat, 1);
        @(negedge clk);
        rr[1] = 1; aa[1] = 32'h44; mm[1] = 0;
        #1;
        chk("w0_stall_c0", 32'(stl_o[1]), 1);
        for (int c = 1; c <= 6; c++) begin
            bit ea;
            @(negedge clk);
            ea = (c == 1 || c == 3 || c == 5);
            chk($sformatf("w0_ack_c%0d", c), 32'(ack_o[1]), 32'(ea));
            chk($sformatf("w0_stall_c%0d", c), 32'(stl_o[1]),
                32'(c <= 5 && !ea));
            chk($sformatf("w0_rdata_c%0d", c), rd_o[1],
                ea ? 32'h5A5A5A5A : 32'h0);
            if (c == 5) rr[1] = 0;
        end

        // Randomized traffic against the model (WAIT_CYCLES=3).
        for (int i = 0; i < 64; i++) begin
            logic [31:0] er;
            bit ee;
            model(0, 1, 32'(i * 4), 32'h0, 3'b000, er, ee);
            txn(2, 0, 1, 32'(i * 4), 32'h0, 3'b000, ro, eo, lat, sbad);
        end
        for (int i = 0; i < 150; i++) begin
            bit r, w, ee;
            logic [31:0] a, d, er;
            logic [2:0] m;
            int k = $urandom_range(0, 19);
            r = (k < 9) || (k >= 18);
            w = (k >= 9);
            a = ($urandom_range(0, 19) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                             : $urandom_range(0, 255);
            d = $urandom;
            m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                : 3'($urandom_range(0, 4) == 4 ? 0 :
                     (32'h06520 >> (4 * $urandom_range(0, 3))) & 7);
            model(r, w, a, d, m, er, ee);
            txn(2, r, w, a, d, m, ro, eo, lat, sbad);
            chk($sformatf("rnd%0d_rdata", i), ro, er);
            chk($sformatf("rnd%0d_err", i), 32'(eo), 32'(ee));
            chk($sformatf("rnd%0d_lat", i), lat, 4);
            chk($sformatf("rnd%0d_stall", i), 32'(sbad), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, data memory size in 32-bit words (power of two, 16..65536).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_read  input  1  MEM-stage load request; held until ack.
REQ-006 req_write  input  1  MEM-stage store request; held until ack.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; the low byte or halfword is used for narrow stores.
REQ-009 acc_mode  input  3  000 word, 001 half unsigned, 010 byte unsigned, 101 half signed, 110 byte signed.
REQ-010 rdata  output  32  load data, extended to 32 bits; valid only while ack=1.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  completion with error; valid only while ack=1.
REQ-013 stall  output  1  combinational; equals (req_read|req_write) & ~ack; drives the hold (wren low) of upstream pipeline registers and the PC.

Function
REQ-014 FSM states: IDLE, WAIT, ACK.
REQ-015 IDLE: if req_read|req_write, latch addr, wdata, acc_mode and req type; go to WAIT with counter=WAIT_CYCLES-1, or to ACK directly if WAIT_CYCLES=0.
REQ-016 WAIT: counter decrements each cycle; at counter=0 go to ACK.
REQ-017 ACK: ack=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Latency: ack asserts exactly WAIT_CYCLES+1 cycles after the cycle in which the request was sampled in IDLE.
REQ-019 Back-to-back requests: a request present in the cycle after ACK is sampled in IDLE, giving one IDLE cycle between transactions.
REQ-020 Inputs changing or deasserting during WAIT/ACK are ignored; the latched transaction completes and ack still pulses.
REQ-021 Memory is little-endian; word index = addr[31:2].
REQ-022 Store commits on the clock edge that enters ACK; only the addressed byte lanes change.
REQ-023 Load data is read from the array at the same point, so a load sees all previously acked stores.
REQ-024 Load extension: unsigned modes zero-extend; signed modes sign-extend from bit 7 (byte) or bit 15 (half).
REQ-025 Error conditions, each completing with ack=1, err=1, rdata=0 and no memory write:
  - misaligned access: word with addr[1:0]!=0, or half with addr[0]=1;
  - addr[31:2] >= DEPTH;
  - acc_mode not listed in REQ-009;
  - req_read and req_write both set when sampled.
REQ-026 Outside ACK: rdata=0, err=0.

Reset
REQ-027 reset=1 at a clock edge forces IDLE, counter=0, ack=0, err=0, rdata=0 on the following cycle, regardless of state.
REQ-028 Reset mid-transaction aborts the transaction: no store commits and no ack is issued.
REQ-029 Memory contents are not cleared by reset.
REQ-030 reset has priority over any request sampled in the same cycle.

Verification
REQ-031 WAIT_CYCLES=1: word store 0xDEADBEEF to 0x10, then word load from 0x10 -> each ack at +2 cycles, load rdata=0xDEADBEEF, err=0, stall high until ack.
REQ-032 Byte stores 0x80 to 0x21 and 0x7F to 0x22 over word 0x20=0x00000000 -> word load 0x007F8000; signed byte load 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Signed half load at 0x22 after word store 0x8001_1234 to 0x20 -> 0xFFFF8001; half load at 0x23 -> err=1, rdata=0, memory unchanged.
REQ-034 WAIT_CYCLES=0: load request held continuously for 3 transactions -> ack on cycles 1, 3, 5; stall low only in ack cycles.
REQ-035 Store issued, reset asserted in WAIT -> next cycle IDLE, ack never pulses, target word keeps its old value.
REQ-036 DEPTH=1024: load from 0x00001000 -> err=1; req_read and req_write both high -> err=1, no write.
